// File: rtl/bit_serializer8_pkg.sv
// Shared types and sizes for the 8-bit parallel-to-serial converter.
package bit_serializer_pkg;
    typedef enum logic {IDLE, SHIFT} ser_state_t;
    localparam int NBITS = 8;
    localparam int IDXW  = 3;
endpackage

// File: rtl/bit_serializer8_if.sv
// Producer-side word handshake plus consumer-side bit handshake of the serializer.
interface bit_serializer8_if;
    import bit_serializer_pkg::*;

    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_data;
    logic             out_val;
    logic             out_rdy;
    logic             out_bit;
    logic             out_last;
    logic             busy;

    // master is the surrounding system (byte producer + bit consumer)
    modport master (
        output in_val, in_data, out_rdy,
        input  in_rdy, out_val, out_bit, out_last, busy
    );

    modport slave (
        input  in_val, in_data, out_rdy,
        output in_rdy, out_val, out_bit, out_last, busy
    );
endinterface

// File: rtl/bit_serializer8_mux.sv
// Team 8:1 one-bit mux; selects one bit of the held word.
module Mux8_1b_RTL (
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    input  logic       in6,
    input  logic       in7,
    input  logic [2:0] sel,
    output logic       out
);
    always_comb begin
        out = in0;
        case (sel)
            3'd0: out = in0;
            3'd1: out = in1;
            3'd2: out = in2;
            3'd3: out = in3;
            3'd4: out = in4;
            3'd5: out = in5;
            3'd6: out = in6;
            3'd7: out = in7;
            default: out = in0;
        endcase
    end
endmodule

// File: rtl/bit_serializer8.sv
// Captures one byte on a val/rdy port and emits it one bit per accepted beat,
// flagging the eighth bit; a new word may be captured on the final beat.
module bit_serializer8
    import bit_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bit_serializer8_if.slave   bus
);
    ser_state_t       state_q;
    logic [NBITS-1:0] word_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  idx_d;
    logic [IDXW-1:0]  sel;
    logic             shifting;
    logic             last;
    logic             beat;
    logic             rdy;
    logic             capture;
    logic             mux_bit;

    assign shifting = (state_q == SHIFT);
    assign last     = shifting && (idx_q == IDXW'(NBITS - 1));
    assign beat     = shifting && bus.out_rdy;
    // Combinational from out_rdy so the next word lands on the final beat with no bubble.
    assign rdy      = (state_q == IDLE) || (last && bus.out_rdy);
    assign capture  = bus.in_val && rdy;
    assign idx_d    = idx_q + 1'b1;
    assign sel      = LSB_FIRST ? idx_q : (IDXW'(NBITS - 1) - idx_q);

    Mux8_1b_RTL u_mux (
        .in0 (word_q[0]),
        .in1 (word_q[1]),
        .in2 (word_q[2]),
        .in3 (word_q[3]),
        .in4 (word_q[4]),
        .in5 (word_q[5]),
        .in6 (word_q[6]),
        .in7 (word_q[7]),
        .sel (sel),
        .out (mux_bit)
    );

    assign bus.in_rdy   = rdy;
    assign bus.out_val  = shifting;
    assign bus.out_bit  = shifting && mux_bit;
    assign bus.out_last = last;
    assign bus.busy     = shifting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        word_q  <= bus.in_data;
                        idx_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        // idx wraps 7 -> 0 on the final beat, ready for the next word
                        idx_q <= idx_d;
                        if (last) begin
                            if (capture) word_q  <= bus.in_data;
                            else         state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serializer8.sv
// Drives an LSB-first and an MSB-first serializer in lockstep against a bit-queue model.
module tb_bit_serializer8;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_serializer8_if ifl ();
    bit_serializer8_if ifm ();

    bit_serializer8 #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(ifl.slave));
    bit_serializer8 #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(ifm.slave));

    int checks = 0;
    int errors = 0;

    // Model: pending bits in emission order for each instance
    bit qL[$];
    bit qM[$];
    bit gotL[$];
    bit gotM[$];
    bit last_cap;

    typedef struct {
        string      nm;
        logic [7:0] data;
        int         mode;   // 0: out_rdy always 1, 1: out_rdy pattern 1,0,0,...
        logic [7:0] exp_l;  // emitted bits, first emitted at MSB
        logic [7:0] exp_m;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] pack(input bit q[$]);
        logic [15:0] r = '0;
        foreach (q[i]) r = {r[14:0], q[i]};
        return r;
    endfunction

    function automatic logic pat(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 3) == 0);
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        ifl.in_val = v; ifl.in_data = d; ifl.out_rdy = r;
        ifm.in_val = v; ifm.in_data = d; ifm.out_rdy = r;
    endtask

    // One cycle: drive, compare at negedge, advance the model at posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic m_rdy, m_val, cap, beat;
        drive(v, d, r);
        @(negedge clk);
        m_val = (qL.size() != 0);
        m_rdy = (qL.size() == 0) || (qL.size() == 1 && r);
        chk("L_in_rdy",   16'(ifl.in_rdy),   16'(m_rdy));
        chk("L_out_val",  16'(ifl.out_val),  16'(m_val));
        chk("L_busy",     16'(ifl.busy),     16'(m_val));
        chk("L_out_last", 16'(ifl.out_last), 16'(qL.size() == 1));
        chk("L_out_bit",  16'(ifl.out_bit),  16'(m_val ? qL[0] : 1'b0));
        chk("M_in_rdy",   16'(ifm.in_rdy),   16'(m_rdy));
        chk("M_out_val",  16'(ifm.out_val),  16'(m_val));
        chk("M_out_last", 16'(ifm.out_last), 16'(qM.size() == 1));
        chk("M_out_bit",  16'(ifm.out_bit),  16'(m_val ? qM[0] : 1'b0));
        cap  = v && m_rdy;
        beat = m_val && r;
        if (beat) begin
            gotL.push_back(ifl.out_bit);
            gotM.push_back(ifm.out_bit);
        end
        @(posedge clk);
        if (beat) begin
            void'(qL.pop_front());
            void'(qM.pop_front());
        end
        if (cap) begin
            for (int i = 0; i < 8; i++) begin
                qL.push_back(d[i]);
                qM.push_back(d[7-i]);
            end
        end
        last_cap = cap;
        #1;
    endtask

    // Asserted between edges; outputs must clear before the next clock edge.
    task automatic async_reset();
        drive(1'b0, 8'h00, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_in_rdy",   16'(ifl.in_rdy),   16'd1);
        chk("rst_out_val",  16'(ifl.out_val),  16'd0);
        chk("rst_busy",     16'(ifl.busy),     16'd0);
        chk("rst_out_bit",  16'(ifl.out_bit),  16'd0);
        chk("rst_out_last", 16'(ifl.out_last), 16'd0);
        chk("rst_M_out_val", 16'(ifm.out_val), 16'd0);
        qL.delete(); qM.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_word(input string nm, input logic [7:0] d, input int mode,
                            input logic [7:0] exp_l, input logic [7:0] exp_m);
        int k = 0;
        gotL.delete(); gotM.delete();
        last_cap = 1'b0;
        while (!last_cap && k < 20) begin step(1'b1, d, pat(mode, k)); k++; end
        while (qL.size() != 0 && k < 80) begin step(1'b0, 8'h00, pat(mode, k)); k++; end
        chk({nm, "_drain"}, 16'(qL.size()), 16'd0);
        chk({nm, "_nbeats"}, 16'(gotL.size()), 16'd8);
        chk({nm, "_seq_lsb"}, pack(gotL), {8'h00, exp_l});
        chk({nm, "_seq_msb"}, pack(gotM), {8'h00, exp_m});
    endtask

    initial begin
        tbl[0] = '{"A5",      8'hA5, 0, 8'b10100101, 8'b10100101};
        tbl[1] = '{"01",      8'h01, 0, 8'b10000000, 8'b00000001};
        tbl[2] = '{"3C_stall", 8'h3C, 1, 8'b00111100, 8'b00111100};
        tbl[3] = '{"C1_stall", 8'hC1, 1, 8'b10000011, 8'b11000001};
        tbl[4] = '{"5A",      8'h5A, 0, 8'b01011010, 8'b01011010};

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        #1;
        chk("init_in_rdy",  16'(ifl.in_rdy),  16'd1);
        chk("init_out_val", 16'(ifl.out_val), 16'd0);
        chk("init_busy",    16'(ifl.busy),    16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_word(tbl[i].nm, tbl[i].data, tbl[i].mode, tbl[i].exp_l, tbl[i].exp_m);

        // Back-to-back FF then 00 with in_val held high
        begin
            int k = 0;
            gotL.delete(); gotM.delete();
            step(1'b1, 8'hFF, 1'b1); k++;
            last_cap = 1'b0;
            while (!last_cap && k < 20) begin step(1'b1, 8'h00, 1'b1); k++; end
            while (qL.size() != 0 && k < 40) begin step(1'b0, 8'h00, 1'b1); k++; end
            chk("b2b_cycles", 16'(k), 16'd17);
            chk("b2b_seq_lsb", pack(gotL), 16'hFF00);
            chk("b2b_seq_msb", pack(gotM), 16'hFF00);
        end

        // Reset mid-word: 3 beats of F0, then reset, then 0F
        gotL.delete(); gotM.delete();
        step(1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("midword_got3", pack(gotL), 16'h0000);
        async_reset();
        run_word("after_rst", 8'h0F, 0, 8'b11110000, 8'b00001111);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
